bus_mem_responder: RTL and testbench

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/bus_mem_responder.sv | 172 +++++++++++++++++
 tb/tb_bus_mem_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// Bus memory responder: a word-addressed 32-bit array behind a simple
// request/ready handshake with a fixed number of wait cycles per access.
// Illegal requests (misaligned, out of range, or read+write together) are
// answered after one cycle with an error strobe and touch neither the array
// nor the read data register.
module bus_mem_responder #(
    parameter int unsigned MEM_WORDS_LOG2 = 8,
    parameter int unsigned MEM_WAIT       = 2
) (
    input  logic        mem_clk,
    input  logic        mem_rst,
    input  logic [31:0] mem_addr_bus,
    input  logic [31:0] mem_data_in_bus,
    input  logic        mem_rd,
    input  logic        mem_wr,
    output logic [31:0] mem_data_out_bus,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        mem_busy
);

    localparam int unsigned DEPTH     = 1 << MEM_WORDS_LOG2;
    localparam logic [3:0]  WAIT_INIT = 4'(MEM_WAIT);
    localparam bit          NO_WAIT   = (MEM_WAIT == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A request is rejected when it is not word aligned, addresses past the
    // end of the array, or asks for a read and a write at the same time.
    function automatic logic req_illegal(
        input logic [31:0] addr,
        input logic        rd,
        input logic        wr
    );
        logic [31:0] upper;
        upper = addr >> (MEM_WORDS_LOG2 + 2);
        return (addr[1:0] != 2'b00) || (upper != 32'd0) || (rd && wr);
    endfunction

    state_t                    state_r;
    state_t                    state_n;
    logic [3:0]                count_r;
    logic [3:0]                count_n;
    logic [MEM_WORDS_LOG2-1:0] idx_r;
    logic [31:0]               wdata_r;
    logic                      is_wr_r;
    logic                      ready_r;
    logic                      ready_n;
    logic                      err_r;
    logic                      err_n;
    logic [31:0]               dout_r;

    logic                      req_s;
    logic                      illegal_s;
    logic [MEM_WORDS_LOG2-1:0] in_idx_s;
    logic                      accept_s;
    logic                      mem_we_s;
    logic                      rd_load_s;
    logic [MEM_WORDS_LOG2-1:0] mem_idx_s;
    logic [31:0]               mem_wdata_s;

    // Storage is deliberately left out of reset: contents survive mem_rst.
    logic [31:0] mem_r [DEPTH];

    assign req_s     = mem_rd | mem_wr;
    assign illegal_s = req_illegal(mem_addr_bus, mem_rd, mem_wr);
    assign in_idx_s  = mem_addr_bus[MEM_WORDS_LOG2+1:2];

    // Next-state, wait counter and array access decode for the handshake FSM.
    always_comb begin
        state_n     = state_r;
        count_n     = count_r;
        ready_n     = 1'b0;
        err_n       = 1'b0;
        accept_s    = 1'b0;
        mem_we_s    = 1'b0;
        rd_load_s   = 1'b0;
        mem_idx_s   = idx_r;
        mem_wdata_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    accept_s = 1'b1;
                    if (illegal_s) begin
                        state_n = ST_RESP;
                        count_n = 4'd0;
                        ready_n = 1'b1;
                        err_n   = 1'b1;
                    end else if (NO_WAIT) begin
                        // Zero-wait build: the access happens straight from the bus.
                        state_n     = ST_RESP;
                        count_n     = 4'd0;
                        ready_n     = 1'b1;
                        mem_idx_s   = in_idx_s;
                        mem_wdata_s = mem_data_in_bus;
                        mem_we_s    = mem_wr;
                        rd_load_s   = mem_rd;
                    end else begin
                        state_n = ST_WAIT;
                        count_n = WAIT_INIT;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT: begin
                count_n = count_r - 4'd1;
                // "<=" rather than "==" so a corrupted zero count cannot wedge the FSM.
                if (count_r <= 4'd1) begin
                    state_n   = ST_RESP;
                    ready_n   = 1'b1;
                    mem_we_s  = is_wr_r;
                    rd_load_s = ~is_wr_r;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
                count_n = 4'd0;
            end
            default: begin
                state_n = ST_IDLE;
                count_n = 4'd0;
            end
        endcase
    end

    // FSM state, latched request and registered response outputs.
    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            state_r <= ST_IDLE;
            count_r <= 4'd0;
            idx_r   <= '0;
            wdata_r <= 32'd0;
            is_wr_r <= 1'b0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            dout_r  <= 32'd0;
        end else begin
            state_r <= state_n;
            count_r <= count_n;
            ready_r <= ready_n;
            err_r   <= err_n;
            if (accept_s) begin
                idx_r   <= in_idx_s;
                wdata_r <= mem_data_in_bus;
                is_wr_r <= mem_wr;
            end
            if (rd_load_s) begin
                dout_r <= mem_r[mem_idx_s];
            end
        end
    end

    // Array write port; commits only on the edge that enters RESP.
    always_ff @(posedge mem_clk) begin
        if (mem_we_s && !mem_rst) begin
            mem_r[mem_idx_s] <= mem_wdata_s;
        end
    end

    assign mem_data_out_bus = dout_r;
    assign mem_ready        = ready_r;
    assign mem_err          = err_r;
    assign mem_busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_bus_mem_responder.sv
// Testbench for bus_mem_responder: one instance with MEM_WAIT=2 and one with
// MEM_WAIT=0, directed vector table, hand-written multi-cycle sequences and a
// randomized phase checked against an array-based reference model.
module tb_bus_mem_responder;

    localparam int LOG2 = 8;
    localparam int W0   = 2;
    localparam int W1   = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    wire  [31:0] dout0;
    wire  [31:0] dout1;
    wire  [1:0]  ready;
    wire  [1:0]  err;
    wire  [1:0]  busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_mem_responder #(.MEM_WORDS_LOG2(LOG2), .MEM_WAIT(W0)) dut0 (
        .mem_clk(clk), .mem_rst(rst),
        .mem_addr_bus(addr[0]), .mem_data_in_bus(din[0]),
        .mem_rd(rd[0]), .mem_wr(wr[0]),
        .mem_data_out_bus(dout0), .mem_ready(ready[0]),
        .mem_err(err[0]), .mem_busy(busy[0])
    );

    bus_mem_responder #(.MEM_WORDS_LOG2(LOG2), .MEM_WAIT(W1)) dut1 (
        .mem_clk(clk), .mem_rst(rst),
        .mem_addr_bus(addr[1]), .mem_data_in_bus(din[1]),
        .mem_rd(rd[1]), .mem_wr(wr[1]),
        .mem_data_out_bus(dout1), .mem_ready(ready[1]),
        .mem_err(err[1]), .mem_busy(busy[1])
    );

    typedef struct {
        int          sel;
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        bit          e;
        logic [31:0] q;
        int          lat;
    } vec_t;

    // Reference model state
    logic [31:0] mdl    [2][256];
    logic [31:0] last_q [2];

    function automatic vec_t mk(int sel, bit r, bit w, logic [31:0] a,
                                logic [31:0] d, bit e, logic [31:0] q, int lat);
        vec_t v;
        v.sel = sel; v.r = r; v.w = w; v.a = a; v.d = d;
        v.e = e; v.q = q; v.lat = lat;
        return v;
    endfunction

    function automatic logic [31:0] get_dout(int sel);
        return (sel == 0) ? dout0 : dout1;
    endfunction

    function automatic int wait_of(int sel);
        return (sel == 0) ? W0 : W1;
    endfunction

    function automatic bit is_illegal(logic [31:0] a, bit r, bit w);
        return ((a % 32'd4) != 32'd0) || (a >= (32'd4 * (32'd1 << LOG2))) || (r && w);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Issue one request, wait (bounded) for mem_ready, drop the request and
    // confirm the strobe lasts one cycle and the block returns to idle.
    task automatic run_txn(input int sel, input bit r, input bit w,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output int bsy, output logic e,
                           output logic [31:0] q, output int rcyc);
        @(negedge clk);
        rd[sel] = r; wr[sel] = w; addr[sel] = a; din[sel] = d;
        lat = -1; bsy = 0; e = 1'b0; q = 32'd0; rcyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (busy[sel]) bsy++;
            if (ready[sel]) begin
                lat = i; e = err[sel]; q = get_dout(sel); rcyc = cyc;
                break;
            end
        end
        rd[sel] = 1'b0; wr[sel] = 1'b0;
        @(posedge clk); #1;
        chk("ready_one_cycle", {31'd0, ready[sel]}, 32'd0);
        chk("idle_after_resp", {31'd0, busy[sel]}, 32'd0);
    endtask

    // Run a transaction and compare it with the reference model.
    task automatic exec_model(input int sel, input bit r, input bit w,
                              input logic [31:0] a, input logic [31:0] d);
        int          lat, bsy, rc, exp_lat;
        logic        e;
        logic [31:0] q;
        bit          bad;
        bad     = is_illegal(a, r, w);
        exp_lat = bad ? 1 : wait_of(sel) + 1;
        if (!bad && w) mdl[sel][a / 4] = d;
        if (!bad && r) last_q[sel] = mdl[sel][a / 4];
        run_txn(sel, r, w, a, d, lat, bsy, e, q, rc);
        chk("rnd_latency", lat, exp_lat);
        chk("rnd_busy",    bsy, exp_lat);
        chk("rnd_err",     {31'd0, e}, {31'd0, bad});
        chk("rnd_data",    q, last_q[sel]);
    endtask

    vec_t        vt [$];
    int          lat, bsy, rc1, rc2;
    logic        e;
    logic [31:0] q;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt.push_back(mk(0, 0, 1, 32'h10,  32'hDEADBEEF, 0, 32'h0,        3));
        vt.push_back(mk(0, 0, 1, 32'h14,  32'h00000000, 0, 32'h0,        3));
        vt.push_back(mk(0, 1, 0, 32'h14,  32'h0,        0, 32'h0,        3));
        vt.push_back(mk(0, 1, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 3));
        vt.push_back(mk(0, 0, 1, 32'h18,  32'h13579BDF, 0, 32'hDEADBEEF, 3));
        vt.push_back(mk(0, 1, 0, 32'h12,  32'h0,        1, 32'hDEADBEEF, 1));
        vt.push_back(mk(0, 1, 0, 32'h400, 32'h0,        1, 32'hDEADBEEF, 1));
        vt.push_back(mk(0, 1, 1, 32'h14,  32'h11111111, 1, 32'hDEADBEEF, 1));
        vt.push_back(mk(0, 1, 0, 32'h14,  32'h0,        0, 32'h0,        3));
        vt.push_back(mk(0, 0, 1, 32'h11,  32'h77777777, 1, 32'h0,        1));
        vt.push_back(mk(0, 1, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 3));
        vt.push_back(mk(0, 0, 1, 32'h0,   32'h01020304, 0, 32'hDEADBEEF, 3));
        vt.push_back(mk(0, 0, 1, 32'h400, 32'hBADBAD00, 1, 32'hDEADBEEF, 1));
        vt.push_back(mk(0, 1, 0, 32'h0,   32'h0,        0, 32'h01020304, 3));
        vt.push_back(mk(0, 0, 1, 32'h3FC, 32'hA5A5A5A5, 0, 32'h01020304, 3));
        vt.push_back(mk(0, 1, 0, 32'h3FC, 32'h0,        0, 32'hA5A5A5A5, 3));
        vt.push_back(mk(0, 1, 0, 32'h18,  32'h0,        0, 32'h13579BDF, 3));
        vt.push_back(mk(0, 1, 0, 32'hFFFFFFFC, 32'h0,   1, 32'h13579BDF, 1));
        vt.push_back(mk(1, 0, 1, 32'h0,   32'h0000AAAA, 0, 32'h0,        1));
        vt.push_back(mk(1, 0, 1, 32'h4,   32'h00005555, 0, 32'h0,        1));
        vt.push_back(mk(1, 1, 0, 32'h0,   32'h0,        0, 32'h0000AAAA, 1));
        vt.push_back(mk(1, 1, 0, 32'h4,   32'h0,        0, 32'h00005555, 1));
        vt.push_back(mk(1, 1, 0, 32'h2,   32'h0,        1, 32'h00005555, 1));
        vt.push_back(mk(1, 0, 1, 32'h400, 32'hBADBAD00, 1, 32'h00005555, 1));
        vt.push_back(mk(1, 1, 0, 32'h0,   32'h0,        0, 32'h0000AAAA, 1));

        // Reset state
        rst = 1'b1; rd = 2'b00; wr = 2'b00;
        addr[0] = 32'd0; addr[1] = 32'd0; din[0] = 32'd0; din[1] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset_ready", {31'd0, ready[s]}, 32'd0);
            chk("reset_err",   {31'd0, err[s]},   32'd0);
            chk("reset_busy",  {31'd0, busy[s]},  32'd0);
            chk("reset_dout",  get_dout(s),       32'd0);
        end
        rst = 1'b0;

        // Directed vector table; the first entry is sampled on the first edge after reset falls
        for (int i = 0; i < vt.size(); i++) begin
            run_txn(vt[i].sel, vt[i].r, vt[i].w, vt[i].a, vt[i].d, lat, bsy, e, q, rc1);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_busy", i),    bsy, vt[i].lat);
            chk($sformatf("vec%0d_err", i),     {31'd0, e}, {31'd0, vt[i].e});
            chk($sformatf("vec%0d_data", i),    q, vt[i].q);
        end

        // Back-to-back spacing: MEM_WAIT=0 -> 2 cycles, MEM_WAIT=2 -> 4 cycles
        run_txn(1, 1, 0, 32'h0, 32'h0, lat, bsy, e, q, rc1);
        chk("b2b0_first_data", q, 32'h0000AAAA);
        run_txn(1, 1, 0, 32'h4, 32'h0, lat, bsy, e, q, rc2);
        chk("b2b0_second_data", q, 32'h00005555);
        chk("b2b0_spacing", rc2 - rc1, 2);
        run_txn(0, 1, 0, 32'h10, 32'h0, lat, bsy, e, q, rc1);
        run_txn(0, 1, 0, 32'h18, 32'h0, lat, bsy, e, q, rc2);
        chk("b2b2_second_data", q, 32'h13579BDF);
        chk("b2b2_spacing", rc2 - rc1, W0 + 2);

        // Request held past mem_ready is taken as a second identical transaction
        @(negedge clk);
        rd[0] = 1'b1; addr[0] = 32'h10;
        rc1 = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready[0]) begin rc1 = cyc; break; end
        end
        chk("hold_first_seen", {31'd0, (rc1 >= 0)}, 32'd1);
        chk("hold_first_data", dout0, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("hold_gap_idle", {31'd0, busy[0]}, 32'd0);
        @(posedge clk); #1;
        chk("hold_reaccepted", {31'd0, busy[0]}, 32'd1);
        @(posedge clk); #1;
        rd[0] = 1'b0;
        rc2 = -1;
        for (int i = 0; i < 40; i++) begin
            if (ready[0]) begin rc2 = cyc; break; end
            @(posedge clk); #1;
        end
        chk("hold_second_spacing", rc2 - rc1, W0 + 2);
        chk("hold_second_err", {31'd0, err[0]}, 32'd0);
        chk("hold_second_data", dout0, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("hold_no_third_a", {31'd0, busy[0]}, 32'd0);
        @(posedge clk); #1;
        chk("hold_no_third_b", {31'd0, busy[0]}, 32'd0);

        // Reset during WAIT discards the pending write
        run_txn(0, 0, 1, 32'h20, 32'hCAFEF00D, lat, bsy, e, q, rc1);
        chk("rstw_prewrite_err", {31'd0, e}, 32'd0);
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 32'h20; din[0] = 32'h12345678;
        @(posedge clk); #1;
        chk("rstw_in_wait", {31'd0, busy[0]}, 32'd1);
        rst = 1'b1;
        #1;
        wr[0] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            chk("rstw_ready", {31'd0, ready[s]}, 32'd0);
            chk("rstw_err",   {31'd0, err[s]},   32'd0);
            chk("rstw_busy",  {31'd0, busy[s]},  32'd0);
            chk("rstw_dout",  get_dout(s),       32'd0);
        end
        @(posedge clk);
        @(posedge clk); #1;
        chk("rstw_dout_held", dout0, 32'd0);
        rst = 1'b0;
        run_txn(0, 1, 0, 32'h20, 32'h0, lat, bsy, e, q, rc1);
        chk("rstw_read_latency", lat, W0 + 1);
        chk("rstw_old_data", q, 32'hCAFEF00D);

        // Randomized phase against the reference model
        last_q[0] = 32'hCAFEF00D;
        last_q[1] = 32'd0;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 16; k++) begin
                exec_model(s, 1'b0, 1'b1, 32'h100 + 32'(4 * k), $urandom);
            end
            for (int n = 0; n < 60; n++) begin
                int          kind;
                logic [31:0] a;
                bit          r, w;
                kind = $urandom_range(0, 9);
                a    = 32'h100 + 32'(4 * $urandom_range(0, 15));
                r    = ($urandom_range(0, 1) == 1);
                w    = !r;
                case (kind)
                    0:       a = a + 32'($urandom_range(1, 3));
                    1:       a = 32'h400 | $urandom;
                    2:       begin r = 1'b1; w = 1'b1; end
                    default: a = a;
                endcase
                exec_model(s, r, w, a, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
